// File: rtl/alu_operand_sequencer.sv
// Operand sequencer feeding the 8-bit ALU: captures A, B and op code from switches,
// one debounced load press per item, then pulses op_valid once per complete set.

module alu_operand_sequencer_deb #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Accepted level flips only after the synced level has disagreed with it for
  // DEBOUNCE_CYCLES+1 consecutive samples; any agreement restarts the count.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    acc_d   = acc_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != acc_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        acc_d   = ~acc_q;
        press_d = ~acc_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module alu_operand_sequencer #(
  parameter int DATA_W          = 8,
  parameter int OP_W            = 3,
  parameter int MAX_OP          = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_load,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   Cntr,
  output logic              op_valid,
  output logic              op_err,
  output logic [2:0]        stage
);
  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_OP    = 3'd2,
    S_ISSUE = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // bit 0 = load, bit 1 = clear
  logic [1:0] raw_btn;
  logic [1:0] press;

  assign raw_btn = {btn_clear, btn_load};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_btn
      alu_operand_sequencer_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_btn[g]),
        .press (press[g])
      );
    end
  endgenerate

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   cntr_q, cntr_d;
  logic              op_valid_q, op_valid_d;
  logic              op_err_q, op_err_d;
  logic              ld, clr;

  assign ld  = press[0];
  assign clr = press[1];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cntr_d   = cntr_q;
    op_err_d = op_err_q;
    if (clr) begin
      a_d      = '0;
      b_d      = '0;
      cntr_d   = '0;
      op_err_d = 1'b0;
      state_d  = S_A;
    end else begin
      case (state_q)
        S_A: if (ld) begin
          a_d      = sw;
          op_err_d = 1'b0;
          state_d  = S_B;
        end
        S_B: if (ld) begin
          b_d     = sw;
          state_d = S_OP;
        end
        S_OP: if (ld) begin
          if (sw[OP_W-1:0] <= OP_W'(MAX_OP)) begin
            cntr_d   = sw[OP_W-1:0];
            op_err_d = 1'b0;
            state_d  = S_ISSUE;
          end else begin
            op_err_d = 1'b1;
          end
        end
        S_ISSUE: state_d = S_HOLD;
        // Restart press only returns to S_A; it does not also capture A.
        S_HOLD:  if (ld) state_d = S_A;
        default: state_d = S_A;
      endcase
    end
    // Registered so op_valid is high exactly while the FSM sits in S_ISSUE.
    op_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      cntr_q     <= '0;
      op_valid_q <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cntr_q     <= cntr_d;
      op_valid_q <= op_valid_d;
      op_err_q   <= op_err_d;
    end
  end

  assign A        = a_q;
  assign B        = b_q;
  assign Cntr     = cntr_q;
  assign op_valid = op_valid_q;
  assign op_err   = op_err_q;
  assign stage    = state_q;
endmodule
